imm_ext_pipe_stage: RTL and testbench

//  Decode-to-execute pipeline stage for 16-bit instruction immediates. Takes the

---
 rtl/imm_ext_pipe_stage.sv | 92 +++++++++
 tb/tb_imm_ext_pipe_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe_stage.sv
// rtl/imm_ext_pipe_stage.sv - Immediate extension stage with 2-entry skid buffer between decode and ALU operand select.
// Build option: define BRANCH_SHIFT_EN to make ext_mode 11 a sign-extended, left-shifted-by-2 branch offset.
module imm_ext_pipe_stage #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    input  logic [1:0]        ext_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm_out
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] skid;
    logic [DATA_W-1:0] ext;
    logic [IMM_W-1:0]  imm;
    logic              push;
    logic              pop;

    assign imm = instr[IMM_W-1:0];

    // Upper instruction bits carry opcode/register fields this stage ignores.
    wire unused_instr_bits = &{1'b0, instr[DATA_W-1:IMM_W]};

    always_comb begin
        ext = {{(DATA_W-IMM_W){1'b0}}, imm};
        case (ext_mode)
            2'b01:   ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
            2'b10:   ext = {imm, {(DATA_W-IMM_W){1'b0}}};
`ifdef BRANCH_SHIFT_EN
            2'b11:   ext = {{(DATA_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
`else
            2'b11:   ext = {{(DATA_W-IMM_W){1'b0}}, imm};
`endif
            default: ext = {{(DATA_W-IMM_W){1'b0}}, imm};
        endcase
    end

    // Ready depends only on the state register, so there is no combinational path from out_ready.
    assign in_ready  = !rst && (state != TWO);
    assign out_valid = (state != EMPTY);
    assign imm_out   = head;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head  <= ext;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        skid  <= ext;
                        state <= TWO;
                    end else if (push && pop) begin
                        head  <= ext;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head  <= skid;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe_stage.sv
// tb/tb_imm_ext_pipe_stage.sv - Vector table plus scoreboard bench for imm_ext_pipe_stage.
module tb_imm_ext_pipe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [1:0]  ext_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm_out;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb[$];
    logic did_push;
    logic did_pop;

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    imm_ext_pipe_stage #(.IMM_W(16), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .ext_mode  (ext_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm_out   (imm_out)
    );

    function automatic logic [31:0] ext_model(input logic [15:0] imm, input logic [1:0] md);
        logic [31:0] r;
        case (md)
            2'b01:   r = imm[15] ? {16'hffff, imm} : {16'h0000, imm};
            2'b10:   r = {imm, 16'h0000};
`ifdef BRANCH_SHIFT_EN
            2'b11:   r = (imm[15] ? {16'hffff, imm} : {16'h0000, imm}) << 2;
`else
            2'b11:   r = {16'h0000, imm};
`endif
            default: r = {16'h0000, imm};
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive after the falling edge, sample 1ns later, model the upcoming rising edge.
    task automatic step(input logic iv, input logic [15:0] imm, input logic [1:0] md,
                        input logic ordy, input logic fl);
        logic [31:0] e;
        @(negedge clk);
        in_valid  = iv;
        instr     = {16'($urandom), imm};
        ext_mode  = md;
        out_ready = ordy;
        flush     = fl;
        #1;
        did_push = in_valid && in_ready;
        did_pop  = out_valid && out_ready;
        if (did_pop) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("data", imm_out, e);
            end
        end
        if (fl) sb.delete();
        else if (did_push) sb.push_back(ext_model(imm, md));
    endtask

    initial begin
        int pops;
`ifdef BRANCH_SHIFT_EN
        vecs[3] = '{16'hfffe, 2'b11, 32'hfffffff8};
        vecs[7] = '{16'h0004, 2'b11, 32'h00000010};
`else
        vecs[3] = '{16'hfffe, 2'b11, 32'h0000fffe};
        vecs[7] = '{16'h0004, 2'b11, 32'h00000004};
`endif
        vecs[0] = '{16'hdcab, 2'b00, 32'h0000dcab};
        vecs[1] = '{16'hdcab, 2'b01, 32'hffffdcab};
        vecs[2] = '{16'h0123, 2'b10, 32'h01230000};
        vecs[4] = '{16'h7fff, 2'b01, 32'h00007fff};
        vecs[5] = '{16'h8000, 2'b01, 32'hffff8000};
        vecs[6] = '{16'hffff, 2'b10, 32'hffff0000};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; ext_mode = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("reset_imm_out", imm_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_release", {31'd0, in_ready}, 32'd1);

        // Extension table: push, then the word must be presented right after that edge.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, vecs[i].imm, vecs[i].mode, 1'b1, 1'b0);
            check("vec_push_accepted", {31'd0, did_push}, 32'd1);
            step(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
            check("vec_latency_valid", {31'd0, did_pop}, 32'd1);
            check("vec_table_value", imm_out, vecs[i].exp);
        end
        step(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);

        // Back-pressure: two pushes fill the buffer, the third is held upstream.
        step(1'b1, 16'h0001, 2'b00, 1'b0, 1'b0);
        step(1'b1, 16'h0002, 2'b00, 1'b0, 1'b0);
        check("second_push_accepted", {31'd0, did_push}, 32'd1);
        step(1'b1, 16'h0003, 2'b00, 1'b0, 1'b0);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("hold_head", imm_out, 32'h00000001);
        step(1'b1, 16'h0003, 2'b00, 1'b0, 1'b0);
        check("hold_head_stable", imm_out, 32'h00000001);
        step(1'b1, 16'h0003, 2'b00, 1'b1, 1'b0);
        check("drain1_valid", {31'd0, out_valid}, 32'd1);
        check("drain1_no_push", {31'd0, did_push}, 32'd0);
        step(1'b1, 16'h0003, 2'b00, 1'b1, 1'b0);
        check("drain2_valid", {31'd0, out_valid}, 32'd1);
        check("drain2_push", {31'd0, did_push}, 32'd1);
        step(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
        check("drain3_valid", {31'd0, out_valid}, 32'd1);
        check("drain_empty", sb.size(), 32'd0);

        // Streaming: one word per cycle, buffer never reaches two entries.
        pops = 0;
        for (int i = 0; i < 9; i++) begin
            step(i < 8, 16'(16'h0100 + i), 2'(i), 1'b1, 1'b0);
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            if (did_pop) pops++;
        end
        check("stream_pop_count", pops, 32'd8);
        check("stream_drained", sb.size(), 32'd0);

        // Asynchronous reset while full, then flush colliding with a push.
        step(1'b1, 16'haaaa, 2'b01, 1'b0, 1'b0);
        step(1'b1, 16'hbbbb, 2'b01, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        check("pre_reset_full", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_imm_out", imm_out, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        step(1'b1, 16'h1234, 2'b00, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
        check("flush_drops_push", {31'd0, out_valid}, 32'd0);

        // Flush with a held word: buffer empties, next push still flows.
        step(1'b1, 16'h5555, 2'b00, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 2'b00, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
        check("flush_clears_valid", {31'd0, out_valid}, 32'd0);
        step(1'b1, 16'h8001, 2'b10, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
        check("after_flush_pop", {31'd0, did_pop}, 32'd1);
        check("final_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
